// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE state encoding, 4-bit opcodes and the IR capture pattern.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RTI        = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TLR        = 4'hF
  } tap_state_t;

  localparam logic [3:0] OP_EXTEST         = 4'b0000;
  localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'b0001;
  localparam logic [3:0] OP_IDCODE         = 4'b0010;
  localparam logic [3:0] OP_BYPASS         = 4'b1111;

  // Loaded into the IR shift register in Capture-IR; upper bits are zero.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  function automatic logic is_shift_state(input tap_state_t s);
    return (s == SHIFT_DR) || (s == SHIFT_IR);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller state machine; state advances on rising TCK from TMS.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output logic [3:0] state
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge tck) begin
    if (reset) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Standard IEEE 1149.1 transitions; five TMS=1 cycles reach TLR from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:        state_d = tms ? TLR       : RTI;
      RTI:        state_d = tms ? SELECT_DR : RTI;
      SELECT_DR:  state_d = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: state_d = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   state_d = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   state_d = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   state_d = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   state_d = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  state_d = tms ? SELECT_DR : RTI;
      SELECT_IR:  state_d = tms ? TLR       : CAPTURE_IR;
      CAPTURE_IR: state_d = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   state_d = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   state_d = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   state_d = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   state_d = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  state_d = tms ? SELECT_DR : RTI;
      default:    state_d = TLR;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: IR, BYPASS/IDCODE DRs, boundary-chain gating and TDO mux.
// Define JTAG_IDCODE_EN to include the 32-bit ID register and the IDCODE opcode.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic       TCK,
  input  logic       RESET,
  input  logic       TMS,
  input  logic       TDI,
  output logic       TDO,
  output logic       TDO_EN,
  output logic       TDIS,
  input  logic       TDOS_LAST,
  output logic       CAPTURE,
  output logic       UPDATE,
  output logic       MODE_SHIFT_LOAD,
  output logic       MODE_TEST_NORMAL,
  output logic [3:0] STATE
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OP_SAMPLE_PRELOAD);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_BYPASS;
`endif

  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("jtag_tap_controller: IR_WIDTH must be at least 2");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
    $error("jtag_tap_controller: IDCODE_VALUE bit 0 must be 1");
  end

  logic [3:0]          state_raw;
  tap_state_t          state_q;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass_reg;
  logic                sel_chain;
  logic                sel_id;
  logic                tdo_mux;
  logic                cap_en;

  jtag_tap_fsm u_fsm (
    .tck   (TCK),
    .reset (RESET),
    .tms   (TMS),
    .state (state_raw)
  );

  assign state_q = tap_state_t'(state_raw);
  assign STATE   = state_raw;

  // Active IR only moves in TLR or when leaving Update-IR, so decoded
  // controls are stable through every DR scan.
  always_ff @(posedge TCK) begin
    if (RESET || (state_q == TLR)) begin
      ir <= IR_RESET;
    end else if (state_q == UPDATE_IR) begin
      ir <= ir_shift;
    end
  end

  always_ff @(posedge TCK) begin
    if (state_q == CAPTURE_IR) begin
      ir_shift <= IR_CAP_VAL;
    end else if (state_q == SHIFT_IR) begin
      ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge TCK) begin
    if (RESET) begin
      bypass_reg <= 1'b0;
    end else if (state_q == CAPTURE_DR) begin
      bypass_reg <= 1'b0;
    end else if (state_q == SHIFT_DR) begin
      bypass_reg <= TDI;
    end
  end

  // Undefined opcodes fall through to BYPASS.
  always_comb begin
    sel_chain = (ir == IR_EXTEST) || (ir == IR_SAMPLE);
    sel_id    = 1'b0;
`ifdef JTAG_IDCODE_EN
    sel_id    = (ir == IR_IDCODE);
`endif
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_reg;

  always_ff @(posedge TCK) begin
    if (sel_id && (state_q == CAPTURE_DR)) begin
      id_reg <= IDCODE_VALUE;
    end else if (sel_id && (state_q == SHIFT_DR)) begin
      id_reg <= {TDI, id_reg[31:1]};
    end
  end

  assign tdo_mux = (state_q == SHIFT_IR) ? ir_shift[0] :
                   (state_q != SHIFT_DR) ? 1'b0 :
                   sel_chain             ? TDOS_LAST :
                   sel_id                ? id_reg[0] : bypass_reg;
`else
  assign tdo_mux = (state_q == SHIFT_IR) ? ir_shift[0] :
                   (state_q != SHIFT_DR) ? 1'b0 :
                   sel_chain             ? TDOS_LAST : bypass_reg;
`endif

  // Falling-edge stage: TDO leads the shifting rising edge by half a cycle,
  // and the clock gate enable is stable whenever TCK is high.
  always_ff @(negedge TCK) begin
    TDO    <= tdo_mux;
    TDO_EN <= is_shift_state(state_q);
    cap_en <= sel_chain && ((state_q == CAPTURE_DR) || (state_q == SHIFT_DR));
    UPDATE <= sel_chain && (state_q == UPDATE_DR);
  end

  assign CAPTURE          = TCK & cap_en;
  assign TDIS             = TDI;
  assign MODE_SHIFT_LOAD  = (state_q == SHIFT_DR);
  assign MODE_TEST_NORMAL = (ir != IR_EXTEST);

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller with an 8-cell boundary chain model and TDO scoreboard.
module tb_jtag_tap_controller;

  logic       TCK = 1'b0;
  logic       RESET;
  logic       TMS;
  logic       TDI;
  logic       TDO;
  logic       TDO_EN;
  logic       TDIS;
  logic       TDOS_LAST;
  logic       CAPTURE;
  logic       UPDATE;
  logic       MODE_SHIFT_LOAD;
  logic       MODE_TEST_NORMAL;
  logic [3:0] STATE;

  int checks = 0;
  int failures = 0;
  int cap_cnt = 0;
  int upd_cnt = 0;
  int cap0;
  int upd0;

  logic [0:0] exp_q[$];

  logic [7:0] cells = 8'h00;
  logic [7:0] cell_out = 8'h00;
  logic [7:0] sys_in = 8'h00;
  logic       pend_mode = 1'b0;
  logic       pend_tdi = 1'b0;

  jtag_tap_controller dut (
    .TCK              (TCK),
    .RESET            (RESET),
    .TMS              (TMS),
    .TDI              (TDI),
    .TDO              (TDO),
    .TDO_EN           (TDO_EN),
    .TDIS             (TDIS),
    .TDOS_LAST        (TDOS_LAST),
    .CAPTURE          (CAPTURE),
    .UPDATE           (UPDATE),
    .MODE_SHIFT_LOAD  (MODE_SHIFT_LOAD),
    .MODE_TEST_NORMAL (MODE_TEST_NORMAL),
    .STATE            (STATE)
  );

  // Clock and watchdog
  always #5 TCK = ~TCK;

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Boundary chain model: cells[0] first, cells[7] last
  assign TDOS_LAST = cells[7];

  always @(negedge TCK) begin
    #1;
    pend_mode = MODE_SHIFT_LOAD;
    pend_tdi  = TDIS;
  end

  always @(posedge CAPTURE) begin
    if (pend_mode) cells = {cells[6:0], pend_tdi};
    else           cells = sys_in;
    cap_cnt++;
  end

  always @(posedge UPDATE) begin
    cell_out = cells;
    upd_cnt++;
  end

  // Scoreboard monitor: one expected bit per falling edge with TDO_EN high
  always begin
    logic [0:0] exp_bit;
    @(negedge TCK);
    #1;
    if (TDO_EN) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tdo_unexpected: got TDO_EN=1 TDO=%0b expected no shift", TDO);
      end else begin
        exp_bit = exp_q.pop_front();
        if (TDO !== exp_bit[0]) begin
          failures++;
          $display("FAIL tdo: got %0b expected %0b", TDO, exp_bit[0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #2;
  endtask

  // From RTI; every IR scan must first present the capture pattern 1,0,0,0.
  task automatic load_ir(input logic [3:0] op, input logic mode_before, input logic mode_after);
    logic [3:0] cap_bits;
    cap_bits = 4'b0001;
    for (int i = 0; i < 4; i++) exp_q.push_back(cap_bits[i]);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("state_shift_ir", 32'(STATE), 32'hA);
    for (int i = 0; i < 4; i++) step(i == 3, op[i]);
    step(1'b1, 1'b0);
    check("state_update_ir", 32'(STATE), 32'hD);
    check("mode_tn_in_update_ir", 32'(MODE_TEST_NORMAL), 32'(mode_before));
    step(1'b0, 1'b0);
    check("mode_tn_after_update_ir", 32'(MODE_TEST_NORMAL), 32'(mode_after));
  endtask

  // From RTI; n == 0 goes Capture-DR -> Exit1-DR directly.
  task automatic shift_dr(input int n, input logic [31:0] tdi_bits, input logic [31:0] exp_bits);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_bits[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    if (n == 0) begin
      step(1'b1, 1'b0);
      check("state_exit1_dr", 32'(STATE), 32'h1);
      check("msl_exit1_dr", 32'(MODE_SHIFT_LOAD), 32'h0);
    end else begin
      step(1'b0, 1'b0);
      check("state_shift_dr", 32'(STATE), 32'h2);
      check("msl_shift_dr", 32'(MODE_SHIFT_LOAD), 32'h1);
      for (int i = 0; i < n; i++) step(i == n - 1, tdi_bits[i]);
    end
    step(1'b1, 1'b0);
    check("state_update_dr", 32'(STATE), 32'h5);
    step(1'b0, 1'b0);
    check("state_rti", 32'(STATE), 32'hC);
  endtask

  // Directed sequence
  initial begin
    RESET = 1'b1;
    TMS   = 1'b1;
    TDI   = 1'b0;
    @(posedge TCK);
    #2;
    RESET = 1'b0;
    check("reset_state", 32'(STATE), 32'hF);
    check("reset_mode_tn", 32'(MODE_TEST_NORMAL), 32'h1);
    check("reset_msl", 32'(MODE_SHIFT_LOAD), 32'h0);
    repeat (5) step(1'b1, 1'b0);
    check("tlr_state", 32'(STATE), 32'hF);
    check("tlr_tdo", 32'(TDO), 32'h0);
    check("tlr_tdo_en", 32'(TDO_EN), 32'h0);
    check("tlr_update", 32'(UPDATE), 32'h0);

    // Park in Pause-DR, then five TMS=1 cycles must return to TLR
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("state_pause_dr", 32'(STATE), 32'h3);
    check("pause_capture_low", 32'(CAPTURE), 32'h0);
    repeat (5) step(1'b1, 1'b0);
    check("tms5_state", 32'(STATE), 32'hF);
    check("tms5_mode_tn", 32'(MODE_TEST_NORMAL), 32'h1);
    check("no_capture_yet", 32'(cap_cnt), 32'h0);
    check("no_update_yet", 32'(upd_cnt), 32'h0);
    step(1'b0, 1'b0);

    // DR selected straight out of TLR
`ifdef JTAG_IDCODE_EN
    shift_dr(32, 32'h0, 32'h1000_0001);
`else
    shift_dr(3, 32'b101, 32'b010);
`endif

    // BYPASS: TDI 1,0,1 -> TDO 0,1,0
    load_ir(4'b1111, 1'b1, 1'b1);
    shift_dr(3, 32'b101, 32'b010);
    check("bypass_no_capture", 32'(cap_cnt), 32'h0);

    // Undefined opcode behaves as BYPASS: TDI 1,1,0,1 -> TDO 0,1,1,0
    load_ir(4'b0111, 1'b1, 1'b1);
    shift_dr(4, 32'b1011, 32'b0110);

    // Opcode 0010
`ifdef JTAG_IDCODE_EN
    load_ir(4'b0010, 1'b1, 1'b1);
    shift_dr(32, 32'h0, 32'h1000_0001);
`else
    load_ir(4'b0010, 1'b1, 1'b1);
    shift_dr(2, 32'b11, 32'b10);
`endif

    // EXTEST: capture 8'h3A, shift in 8'hA5; TDO shows 3A MSB cell first
    sys_in = 8'h3A;
    load_ir(4'b0000, 1'b1, 1'b0);
    cap0 = cap_cnt;
    upd0 = upd_cnt;
    shift_dr(8, 32'hA5, 32'h5C);
    check("extest_capture_rises", 32'(cap_cnt - cap0), 32'd9);
    check("extest_update_pulses", 32'(upd_cnt - upd0), 32'd1);
    check("extest_cell_out", 32'(cell_out), 32'hA5);
    check("extest_mode_tn", 32'(MODE_TEST_NORMAL), 32'h0);

    // Zero-length shift: capture only, then update the captured data
    sys_in = 8'h5A;
    shift_dr(0, 32'h0, 32'h0);
    check("zero_shift_capture", 32'(cap_cnt - cap0), 32'd10);
    check("zero_shift_update", 32'(upd_cnt - upd0), 32'd2);
    check("zero_shift_cell_out", 32'(cell_out), 32'h5A);

    // SAMPLE_PRELOAD releases the test path
    load_ir(4'b0001, 1'b0, 1'b1);

    // RESET in the middle of an EXTEST Shift-DR
    load_ir(4'b0000, 1'b1, 1'b0);
    sys_in = 8'h80;
    upd0 = upd_cnt;
    exp_q.push_back(1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("pre_reset_shift_dr", 32'(STATE), 32'h2);
    RESET = 1'b1;
    step(1'b0, 1'b0);
    RESET = 1'b0;
    check("mid_reset_state", 32'(STATE), 32'hF);
    check("mid_reset_mode_tn", 32'(MODE_TEST_NORMAL), 32'h1);
    repeat (3) step(1'b1, 1'b0);
    check("mid_reset_no_update", 32'(upd_cnt - upd0), 32'd0);
    check("mid_reset_tdo_en", 32'(TDO_EN), 32'h0);
    check("mid_reset_capture_off", 32'(CAPTURE), 32'h0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

IEEE 1149.1-style TAP controller that sequences the boundary-scan chain built from the team's `simple_cell` boundary cells. It runs the 16-state TAP FSM from TMS and holds a 4-bit instruction register. It also holds the BYPASS register and, optionally, the IDCODE register. It drives the chain's CAPTURE/UPDATE clocks and its MODE_SHIFT_LOAD/MODE_TEST_NORMAL controls, and muxes TDO. It sits between the device JTAG pins and the boundary-scan chain.

## Interface
- IR_WIDTH, 4, instruction register width (≥2)
- IDCODE_VALUE, 32'h1000_0001, IDCODE register contents; bit 0 must be 1
- TCK  in  1  JTAG clock, the only clock; state updates on rising edge
- RESET  in  1  synchronous, active-high reset, sampled on rising TCK
- TMS  in  1  mode select
- TDI  in  1  serial data in
- TDO  out  1  serial data out, registered on falling TCK
- TDO_EN  out  1  high only while shifting (Shift-IR/Shift-DR), registered on falling TCK
- TDIS  out  1  serial input to first boundary cell (= TDI)
- TDOS_LAST  in  1  serial output of last boundary cell
- CAPTURE  out  1  gated TCK to cells (ClockDR)
- UPDATE  out  1  update strobe to cells (UpdateDR)
- MODE_SHIFT_LOAD  out  1  1 = shift, 0 = capture system data
- MODE_TEST_NORMAL  out  1  1 = normal system path, 0 = test (EXTEST)
- STATE  out  4  current TAP state (debug)

## Operation
- FSM: the standard 16 TAP states, with standard TMS transitions. RESET or five consecutive TMS=1 cycles give Test-Logic-Reset (TLR).
- Reset values:
  - state = TLR
  - IR = IDCODE, or BYPASS without the macro
  - TDO = 0, TDO_EN = 0
  - CAPTURE = 0, UPDATE = 0
  - MODE_SHIFT_LOAD = 0, MODE_TEST_NORMAL = 1
- Opcodes (IR_WIDTH=4): EXTEST 0000, SAMPLE_PRELOAD 0001, IDCODE 0010, BYPASS 1111. Undefined opcodes decode as BYPASS.
- IR path:
  - Capture-IR loads the shift register with {0…,01}.
  - Shift-IR shifts it LSB first from TDI.
  - Update-IR copies the shift register to the active IR.
  - The active IR changes only in Update-IR or TLR.
- DR selection by active IR:
  - EXTEST and SAMPLE_PRELOAD select the boundary chain (TDO source = TDOS_LAST).
  - IDCODE selects the 32-bit ID register: captures IDCODE_VALUE, shifts LSB first.
  - BYPASS selects a 1-bit register: captures 0.
- MODE_SHIFT_LOAD = 1 in Shift-DR, 0 otherwise.
- MODE_TEST_NORMAL = 0 iff the active IR = EXTEST; it changes only after the Update-IR falling edge.
- CAPTURE and UPDATE are driven only when the chain is selected; otherwise both are held 0.
- Mid-operation RESET: abandons the shift, leaves IR and DR shift contents undefined but unused, and applies the reset values on the next rising TCK.

## Timing
- All state, IR and DR registers update on rising TCK. TDO, TDO_EN and the gate enables update on falling TCK (same clock, opposite edge).
- CAPTURE = TCK AND cap_en.
  - cap_en is latched on falling TCK and is high while the state is Capture-DR or Shift-DR.
  - Result: the cell's rising edge coincides with the rising TCK that ends that state. This gives one CAPTURE rise for Capture-DR plus one per Shift-DR cycle, glitch-free.
- UPDATE: goes high on the falling TCK while in Update-DR, and low on the next falling TCK. So it is exactly one half-cycle-offset pulse per Update-DR visit.
- TDO latency: the bit shifted out at rising edge n is presented at the falling edge before edge n.
- Shift-DR of N cycles on an N-cell chain moves exactly N bits. Zero-cycle shift (Capture-DR→Exit1-DR) produces a capture only.
- Pause-DR/Pause-IR hold all registers; CAPTURE stays low.

## Configuration
- JTAG_IDCODE_EN defined: the ID register and the IDCODE opcode exist; TLR loads IDCODE.
- Macro undefined: there is no ID register, opcode 0010 decodes as BYPASS, and TLR loads BYPASS.

## Structure
- Package jtag_pkg holds:
  - TAP state encoding (IEEE 4-bit: TLR=4'hF, RTI=4'hC, Select-DR=4'h7, Capture-DR=4'h6, Shift-DR=4'h2, Exit1-DR=4'h1, Pause-DR=4'h3, Exit2-DR=4'h0, Update-DR=4'h5, Select-IR=4'h4, Capture-IR=4'hE, Shift-IR=4'hA, Exit1-IR=4'h9, Pause-IR=4'hB, Exit2-IR=4'h8, Update-IR=4'hD)
  - opcode constants
  - IR capture constant
- Sub-module jtag_tap_fsm: the state register and next-state logic only. The top level holds IR, DRs, gating and the TDO mux.

## Test plan
- RESET high one cycle, then TMS=1 ×5 → STATE=4'hF, MODE_TEST_NORMAL=1, CAPTURE/UPDATE never toggle.
- Reset, go to Shift-DR, shift 32 cycles (macro on) → TDO emits 32'h1000_0001 LSB first, TDO_EN high for exactly 32 falling edges.
- Load IR=1111 → Shift-DR with TDI pattern 1,0,1 → TDO = 0,1,0 (1-cycle bypass delay), and CAPTURE stays 0.
- Load IR=0000 (EXTEST) on an 8-cell chain:
  - MODE_TEST_NORMAL falls after Update-IR.
  - Capture-DR then 8 Shift-DR cycles give 9 CAPTURE rises.
  - Update-DR gives exactly 1 UPDATE pulse; cells output the shifted byte 8'hA5.
- Shift IR, read IR capture → first two TDO bits = 1,0. Load opcode 0111 → behaves as BYPASS.
- Assert RESET during Shift-DR (EXTEST active) → next rising TCK: STATE=4'hF, MODE_TEST_NORMAL=1, no UPDATE pulse.
